// File: rtl/ps2_key_sender.sv
// PS/2 keyboard emulator: maps an accepted ASCII character to its set-2 scan code and
// sends make, break prefix (F0) and make again as three device-to-host frames.
//
// state | meaning
// IDLE  | lines released, ready=1, waiting for a valid character
// SEND  | shifting the 11 bits of the current frame onto ps2_data/ps2_clk
// GAP   | both lines released for GAP_CYC cycles after a frame
module ps2_key_sender #(
    parameter int HALF_CYC = 2000,
    parameter int GAP_CYC  = 4000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ascii_in,
    input  logic       valid,
    output logic       ready,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int PW = (HALF_CYC > 0) ? $clog2(2 * HALF_CYC) : 1;
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [PW-1:0] PHASE_LOAD = PW'(2 * HALF_CYC - 1);
    localparam logic [PW-1:0] PHASE_FALL = PW'(HALF_CYC);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   phase_cnt;
    logic [3:0]      bit_cnt;
    logic [1:0]      frame_idx;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      code;
    logic [8:0]      map_res;
    logic [10:0]     cur_word;

    // Result is {mapped, scan_code}.
    function automatic logic [8:0] map_ascii(input logic [7:0] c);
        logic [8:0] r;
        r = 9'h000;
        case (c)
            8'h61: r = {1'b1, 8'h1C};
            8'h62: r = {1'b1, 8'h32};
            8'h63: r = {1'b1, 8'h21};
            8'h64: r = {1'b1, 8'h23};
            8'h65: r = {1'b1, 8'h24};
            8'h66: r = {1'b1, 8'h2B};
            8'h67: r = {1'b1, 8'h34};
            8'h68: r = {1'b1, 8'h33};
            8'h69: r = {1'b1, 8'h43};
            8'h6A: r = {1'b1, 8'h3B};
            8'h6B: r = {1'b1, 8'h42};
            8'h6C: r = {1'b1, 8'h4B};
            8'h6D: r = {1'b1, 8'h3A};
            8'h6E: r = {1'b1, 8'h31};
            8'h6F: r = {1'b1, 8'h44};
            8'h70: r = {1'b1, 8'h4D};
            8'h71: r = {1'b1, 8'h15};
            8'h72: r = {1'b1, 8'h2D};
            8'h73: r = {1'b1, 8'h1B};
            8'h74: r = {1'b1, 8'h2C};
            8'h75: r = {1'b1, 8'h3C};
            8'h76: r = {1'b1, 8'h2A};
            8'h77: r = {1'b1, 8'h1D};
            8'h78: r = {1'b1, 8'h22};
            8'h79: r = {1'b1, 8'h35};
            8'h7A: r = {1'b1, 8'h1A};
            8'h30: r = {1'b1, 8'h45};
            8'h31: r = {1'b1, 8'h16};
            8'h32: r = {1'b1, 8'h1E};
            8'h33: r = {1'b1, 8'h26};
            8'h34: r = {1'b1, 8'h25};
            8'h35: r = {1'b1, 8'h2E};
            8'h36: r = {1'b1, 8'h36};
            8'h37: r = {1'b1, 8'h3D};
            8'h38: r = {1'b1, 8'h3E};
            8'h39: r = {1'b1, 8'h46};
            8'h2C: r = {1'b1, 8'h41};
            8'h2E: r = {1'b1, 8'h49};
            8'h2F: r = {1'b1, 8'h4A};
            8'h3B: r = {1'b1, 8'h4C};
            8'h27: r = {1'b1, 8'h52};
            8'h5B: r = {1'b1, 8'h54};
            8'h5D: r = {1'b1, 8'h5B};
            8'h5C: r = {1'b1, 8'h5D};
            8'h60: r = {1'b1, 8'h0E};
            8'h2D: r = {1'b1, 8'h4E};
            8'h3D: r = {1'b1, 8'h55};
            8'h2B: r = {1'b1, 8'h79};
            8'h2A: r = {1'b1, 8'h7C};
            8'h08: r = {1'b1, 8'h66};
            8'h09: r = {1'b1, 8'h0D};
            8'h0D: r = {1'b1, 8'h5A};
            8'h1B: r = {1'b1, 8'h76};
            8'h20: r = {1'b1, 8'h29};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Bit 0 is the start bit; parity makes the data-plus-parity ones count odd.
    function automatic logic [10:0] frame_word(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign map_res  = map_ascii(ascii_in);
    assign cur_word = frame_word((frame_idx == 2'd1) ? 8'hF0 : code);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            ready     <= 1'b1;
            err       <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            phase_cnt <= '0;
            bit_cnt   <= 4'd0;
            frame_idx <= 2'd0;
            gap_cnt   <= '0;
            code      <= 8'h00;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        if (map_res[8]) begin
                            code      <= map_res[7:0];
                            state     <= SEND;
                            ready     <= 1'b0;
                            frame_idx <= 2'd0;
                            bit_cnt   <= 4'd0;
                            phase_cnt <= PHASE_LOAD;
                            ps2_clk   <= 1'b1;
                            ps2_data  <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (phase_cnt == '0) begin
                        if (bit_cnt == 4'd10) begin
                            state    <= GAP;
                            gap_cnt  <= GAP_LOAD;
                            ps2_clk  <= 1'b1;
                            ps2_data <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            phase_cnt <= PHASE_LOAD;
                            ps2_clk   <= 1'b1;
                            ps2_data  <= cur_word[bit_cnt + 4'd1];
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                        if (phase_cnt == PHASE_FALL) begin
                            ps2_clk <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (frame_idx == 2'd2) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end else begin
                            state     <= SEND;
                            frame_idx <= frame_idx + 2'd1;
                            bit_cnt   <= 4'd0;
                            phase_cnt <= PHASE_LOAD;
                            ps2_clk   <= 1'b1;
                            ps2_data  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: cycle-level waveform model from the frame timing rules plus a
// PS/2 receiver model that decodes frames back to scan codes and ASCII.
module tb_ps2_key_sender;

    localparam int H  = 2;
    localparam int G  = 3;
    localparam int NF = 22 * H + G;
    localparam int NC = 3 * NF;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready, err, ps2_clk, ps2_data;

    always #5 clk = ~clk;

    ps2_key_sender #(.HALF_CYC(H), .GAP_CYC(G)) dut (
        .clk(clk), .clrn(clrn), .ascii_in(ascii_in), .valid(valid),
        .ready(ready), .err(err), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          map_ok[256];
    logic [7:0]  map_code[256];
    logic [7:0]  mapped_q[$];

    logic [10:0] rx_raw[$];
    logic [7:0]  rx_q[$];
    bit          rx_ok[$];

    // Receiver model: samples data on each falling ps2_clk.
    logic        mon_prev = 1'b1;
    logic [10:0] mon_word = '0;
    int          mon_n = 0;
    always @(negedge clk) begin
        if (!clrn) begin
            mon_n    = 0;
            mon_prev = 1'b1;
        end else begin
            if (mon_prev === 1'b1 && ps2_clk === 1'b0) begin
                mon_word[mon_n] = ps2_data;
                mon_n++;
                if (mon_n == 11) begin
                    rx_raw.push_back(mon_word);
                    rx_q.push_back(mon_word[8:1]);
                    rx_ok.push_back(mon_word[0] == 1'b0 && mon_word[10] == 1'b1
                                    && ((^mon_word[9:1]) == 1'b1));
                    mon_n = 0;
                end
            end
            mon_prev = ps2_clk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    task automatic build_map();
        logic [7:0] lt[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dg[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] sy_a[18] = '{",", ".", "/", ";", "'", "[", "]", "\\", 8'h60, "-", "=", "+", "*",
                                 8'h08, 8'h09, 8'h0D, 8'h1B, 8'h20};
        logic [7:0] sy_c[18] = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h54, 8'h5B, 8'h5D, 8'h0E,
                                 8'h4E, 8'h55, 8'h79, 8'h7C, 8'h66, 8'h0D, 8'h5A, 8'h76, 8'h29};
        for (int i = 0; i < 256; i++) begin
            map_ok[i] = 1'b0;
            map_code[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) begin
            map_ok[8'h61 + i] = 1'b1;
            map_code[8'h61 + i] = lt[i];
        end
        for (int i = 0; i < 10; i++) begin
            map_ok[8'h30 + i] = 1'b1;
            map_code[8'h30 + i] = dg[i];
        end
        for (int i = 0; i < 18; i++) begin
            map_ok[sy_a[i]] = 1'b1;
            map_code[sy_a[i]] = sy_c[i];
        end
        for (int i = 0; i < 256; i++)
            if (map_ok[i]) mapped_q.push_back(8'(i));
    endtask

    function automatic int rev_map(input logic [7:0] code);
        for (int a = 0; a < 256; a++)
            if (map_ok[a] && map_code[a] == code) return a;
        return -1;
    endfunction

    task automatic flush_rx();
        rx_raw.delete();
        rx_q.delete();
        rx_ok.delete();
    endtask

    // Presents c on a cycle where ready=1, so the next rising edge accepts it.
    task automatic accept_char(input logic [7:0] c, input bit hold);
        int t;
        t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_err++;
            $display("FAIL ready_wait: ready=%b after %0d cycles, want 1", ready, t);
        end
        ascii_in = c;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    // Called just after the acceptance edge; checks every cycle of the keypress.
    task automatic check_char(input logic [7:0] c, output int lowcnt);
        logic [7:0]  code, b;
        logic [10:0] w;
        logic        ec, ed;
        int          o, f;
        code = map_code[c];
        lowcnt = 0;
        for (int k = 1; k <= NC; k++) begin
            @(negedge clk);
            o = (k - 1) % NF;
            f = (k - 1) / NF;
            if (o < 22 * H) begin
                b  = (f == 1) ? 8'hF0 : code;
                w  = {1'b1, ~^b, b, 1'b0};
                ec = ((o % (2 * H)) < H);
                ed = w[o / (2 * H)];
            end else begin
                ec = 1'b1;
                ed = 1'b1;
            end
            if (ready === 1'b0) lowcnt++;
            n_vec++;
            if ({ps2_clk, ps2_data, ready, err} !== {ec, ed, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL wave char=%h k=%0d clk/data/ready/err=%b%b%b%b want %b%b00",
                         c, k, ps2_clk, ps2_data, ready, err, ec, ed);
            end
        end
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b1 || ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            n_err++;
            $display("FAIL ready_return char=%h ready/clk/data=%b%b%b want 111",
                     c, ready, ps2_clk, ps2_data);
        end
    endtask

    task automatic check_rx(input logic [7:0] c);
        logic [7:0] b0, b1, b2;
        bit ok0, ok1, ok2;
        n_vec++;
        if (rx_q.size() < 3) begin
            n_err++;
            $display("FAIL rx_count char=%h got %0d frames want 3", c, rx_q.size());
            return;
        end
        b0 = rx_q.pop_front(); b1 = rx_q.pop_front(); b2 = rx_q.pop_front();
        ok0 = rx_ok.pop_front(); ok1 = rx_ok.pop_front(); ok2 = rx_ok.pop_front();
        void'(rx_raw.pop_front()); void'(rx_raw.pop_front()); void'(rx_raw.pop_front());
        if (!(ok0 && ok1 && ok2) || b0 !== map_code[c] || b1 !== 8'hF0 || b2 !== map_code[c]) begin
            n_err++;
            $display("FAIL rx_frames char=%h got %h/%h/%h framing=%b%b%b want %h/F0/%h framing=111",
                     c, b0, b1, b2, ok0, ok1, ok2, map_code[c], map_code[c]);
        end
        n_vec++;
        if (rev_map(b0) != int'(c)) begin
            n_err++;
            $display("FAIL rx_ascii got %0h want %0h", rev_map(b0), c);
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) begin
            n_err++;
            $display("FAIL reset_state ready/err/clk/data=%b%b%b%b want 1011",
                     ready, err, ps2_clk, ps2_data);
        end
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_letter_a();
        int lowcnt;
        flush_rx();
        accept_char(8'h61, 1'b0);
        check_char(8'h61, lowcnt);
        n_vec++;
        if (lowcnt != 141) begin
            n_err++;
            $display("FAIL ready_low_cycles got %0d want 141", lowcnt);
        end
        n_vec++;
        if (rx_raw.size() != 3 || rx_raw[0] !== 11'b10000111000 || rx_raw[1][9] !== 1'b1) begin
            n_err++;
            $display("FAIL a_bits frames=%0d f0=%b want 10000111000, f1 parity want 1",
                     rx_raw.size(), (rx_raw.size() > 0) ? rx_raw[0] : 11'h0);
        end
        check_rx(8'h61);
    endtask

    task automatic test_back_to_back();
        int lowcnt;
        flush_rx();
        accept_char(8'h30, 1'b1);
        ascii_in = 8'h0D;
        check_char(8'h30, lowcnt);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_char(8'h0D, lowcnt);
        check_rx(8'h30);
        check_rx(8'h0D);
    endtask

    task automatic test_unmapped();
        logic [7:0] u;
        accept_char(8'h41, 1'b1);
        ascii_in = 8'h3F;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL unmapped_err1 err/ready=%b%b want 11", err, ready);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL unmapped_err2 err/ready=%b%b want 11", err, ready);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++;
            if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) begin
                n_err++;
                $display("FAIL unmapped_idle k=%0d ready/err/clk/data=%b%b%b%b want 1011",
                         k, ready, err, ps2_clk, ps2_data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do u = 8'($urandom_range(0, 255)); while (map_ok[u]);
            accept_char(u, 1'b0);
            @(negedge clk);
            n_vec++;
            if ({ready, err, ps2_clk} !== 3'b111) begin
                n_err++;
                $display("FAIL unmapped_rand char=%h ready/err/clk=%b%b%b want 111",
                         u, ready, err, ps2_clk);
            end
            @(negedge clk);
            n_vec++;
            if (err !== 1'b0) begin
                n_err++;
                $display("FAIL unmapped_pulse char=%h err=%b want 0", u, err);
            end
        end
    endtask

    task automatic test_decode();
        logic [7:0] chars[$];
        int lowcnt;
        chars.push_back(8'h20);
        chars.push_back(8'h2B);
        for (int i = 0; i < 6; i++)
            chars.push_back(mapped_q[$urandom_range(0, mapped_q.size() - 1)]);
        foreach (chars[i]) begin
            flush_rx();
            accept_char(chars[i], 1'b0);
            check_char(chars[i], lowcnt);
            check_rx(chars[i]);
        end
    endtask

    task automatic test_reset_midframe();
        int lowcnt;
        flush_rx();
        accept_char(8'h71, 1'b0);
        repeat (69) @(negedge clk);
        clrn = 1'b0;
        #1;
        n_vec++;
        if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) begin
            n_err++;
            $display("FAIL midreset_async ready/err/clk/data=%b%b%b%b want 1011",
                     ready, err, ps2_clk, ps2_data);
        end
        @(negedge clk);
        n_vec++;
        if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) begin
            n_err++;
            $display("FAIL midreset_next ready/err/clk/data=%b%b%b%b want 1011",
                     ready, err, ps2_clk, ps2_data);
        end
        @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if ({ready, ps2_clk, ps2_data} !== 3'b111) begin
            n_err++;
            $display("FAIL midreset_idle ready/clk/data=%b%b%b want 111", ready, ps2_clk, ps2_data);
        end
        flush_rx();
        accept_char(8'h7A, 1'b0);
        check_char(8'h7A, lowcnt);
        check_rx(8'h7A);
    endtask

    task automatic test_busy_valid();
        int lowcnt;
        flush_rx();
        accept_char(8'h78, 1'b0);
        fork
            check_char(8'h78, lowcnt);
            begin
                repeat (10) @(negedge clk);
                ascii_in = 8'h62;
                valid = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_char(8'h62, lowcnt);
        check_rx(8'h78);
        check_rx(8'h62);
    endtask

    initial begin
        build_map();
        test_reset();
        test_letter_a();
        test_back_to_back();
        test_unmapped();
        test_decode();
        test_reset_midframe();
        test_busy_valid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
